// File: rtl/mult_cs_pipe.sv
// Pipelined carry-save multiplier with per-transaction signed/unsigned mode; MULT_CS_CPA_EN adds a final CPA slice and the product port.
// Latency STAGES cycles (STAGES+1 with CPA). Bubble-collapsing valid chain: in_ready falls only when every slice is full and out_ready is low.
module mult_cs_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 tc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   sum,
    output logic [2*WIDTH-1:0]   carry,
    output logic                 out_tc
`ifdef MULT_CS_CPA_EN
    ,
    output logic [2*WIDTH-1:0]   product
`endif
);
    localparam int PW   = 2 * WIDTH;
    localparam int ROWS = WIDTH + 1;
`ifdef MULT_CS_CPA_EN
    localparam int NS = STAGES + 1;
`else
    localparam int NS = STAGES;
`endif

    logic [NS-1:0]    v_q;
    logic [NS-1:0]    t_q;
    logic [NS-1:0]    nxt_t;
    logic [NS:0]      ld;
    logic [NS:0]      vin;
    logic [PW-1:0]    s_q   [NS];
    logic [PW-1:0]    c_q   [NS];
    logic [PW-1:0]    nxt_s [NS];
    logic [PW-1:0]    nxt_c [NS];
    logic [WIDTH-1:0] a_q   [NS];
    logic [WIDTH-1:0] b_q   [NS];
    logic [WIDTH-1:0] nxt_a [NS];
    logic [WIDTH-1:0] nxt_b [NS];

    // Row k < WIDTH is b[k]*a at weight 2^k. In signed mode the MSB row carries
    // negative weight, so it is inverted and row WIDTH supplies the +1.
    function automatic logic [PW-1:0] pp_row(input logic [WIDTH-1:0] fa,
                                             input logic [WIDTH-1:0] fb,
                                             input logic             ftc,
                                             input int               k);
        logic [PW-1:0]    aext;
        logic [PW-1:0]    sh;
        logic [WIDTH-1:0] bsel;
        logic [PW-1:0]    r;
        aext = ftc ? {{WIDTH{fa[WIDTH-1]}}, fa} : {{WIDTH{1'b0}}, fa};
        sh   = aext << k;
        bsel = fb >> k;
        r    = '0;
        if (k < WIDTH) begin
            if (bsel[0]) r = (ftc && (k == WIDTH - 1)) ? ~sh : sh;
        end else begin
            r = {{(PW-1){1'b0}}, ftc & fb[WIDTH-1]};
        end
        return r;
    endfunction

    // Slice i loads when empty or when its successor is taking its contents.
    always_comb begin
        ld     = '0;
        ld[NS] = out_ready;
        for (int i = NS - 1; i >= 0; i--) begin
            ld[i] = !v_q[i] || ld[i + 1];
        end
    end

    assign vin      = {v_q, in_valid};
    assign in_ready = ld[0];

    for (genvar g = 0; g < STAGES; g++) begin : g_red
        localparam int LO = g * ROWS / STAGES;
        localparam int HI = (g + 1) * ROWS / STAGES;

        logic [PW-1:0]    src_s;
        logic [PW-1:0]    src_c;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic             src_t;
        logic [PW-1:0]    acc_s;
        logic [PW-1:0]    acc_c;
        logic [PW-1:0]    row;
        logic [PW-1:0]    tmp;

        if (g == 0) begin : g_head
            assign src_s = '0;
            assign src_c = '0;
            assign src_a = a;
            assign src_b = b;
            assign src_t = tc;
        end else begin : g_body
            assign src_s = s_q[g-1];
            assign src_c = c_q[g-1];
            assign src_a = a_q[g-1];
            assign src_b = b_q[g-1];
            assign src_t = t_q[g-1];
        end

        // This slice folds its share of rows into the running sum/carry pair.
        always_comb begin
            acc_s = src_s;
            acc_c = src_c;
            row   = '0;
            tmp   = '0;
            for (int k = LO; k < HI; k++) begin
                row   = pp_row(src_a, src_b, src_t, k);
                tmp   = acc_s ^ acc_c ^ row;
                acc_c = ((acc_s & acc_c) | (acc_s & row) | (acc_c & row)) << 1;
                acc_s = tmp;
            end
        end

        assign nxt_s[g] = acc_s;
        assign nxt_c[g] = acc_c;
        assign nxt_a[g] = src_a;
        assign nxt_b[g] = src_b;
        assign nxt_t[g] = src_t;
    end

`ifdef MULT_CS_CPA_EN
    logic [PW-1:0] prod_q;

    assign nxt_s[STAGES] = s_q[STAGES-1];
    assign nxt_c[STAGES] = c_q[STAGES-1];
    assign nxt_a[STAGES] = '0;
    assign nxt_b[STAGES] = '0;
    assign nxt_t[STAGES] = t_q[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
        end else if (ld[STAGES] && vin[STAGES]) begin
            prod_q <= s_q[STAGES-1] + c_q[STAGES-1];
        end
    end

    assign product = prod_q;
`endif

    // Data registers only move when a valid transaction enters, keeping stalled outputs steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            t_q <= '0;
            for (int i = 0; i < NS; i++) begin
                s_q[i] <= '0;
                c_q[i] <= '0;
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (ld[i]) begin
                    v_q[i] <= vin[i];
                    if (vin[i]) begin
                        s_q[i] <= nxt_s[i];
                        c_q[i] <= nxt_c[i];
                        a_q[i] <= nxt_a[i];
                        b_q[i] <= nxt_b[i];
                        t_q[i] <= nxt_t[i];
                    end
                end
            end
        end
    end

    assign out_valid = v_q[NS-1];
    assign sum       = s_q[NS-1];
    assign carry     = c_q[NS-1];
    assign out_tc    = t_q[NS-1];

endmodule

// File: tb/tb_mult_cs_pipe.sv
// Bench for mult_cs_pipe (WIDTH=16, STAGES=2): vector table, capacity/backpressure/reset sequences, random stream,
// all results checked through an accept-time scoreboard queue.
module tb_mult_cs_pipe;
    localparam int W  = 16;
    localparam int S  = 2;
    localparam int PW = 2 * W;
`ifdef MULT_CS_CPA_EN
    localparam int LAT = S + 1;
`else
    localparam int LAT = S;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          tc;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] sum;
    logic [PW-1:0] carry;
    logic          out_tc;
`ifdef MULT_CS_CPA_EN
    logic [PW-1:0] product;
`endif

    mult_cs_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .tc        (tc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .out_tc    (out_tc)
`ifdef MULT_CS_CPA_EN
        ,
        .product   (product)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] p;
        logic          t;
    } exp_t;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          t;
        logic [PW-1:0] p;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    exp_t          q[$];
    logic [PW-1:0] cur_exp;
    vec_t          tbl[10];

    logic          stall_prev;
    logic [PW-1:0] sv_s;
    logic [PW-1:0] sv_c;
    logic          sv_t;
`ifdef MULT_CS_CPA_EN
    logic [PW-1:0] sv_p;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic t);
        longint sx;
        longint sy;
        longint r;
        if (t) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'(x);
            sy = longint'(y);
        end
        r = sx * sy;
        return r[PW-1:0];
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(7))
            0:       return '1;
            1:       return {1'b1, {(W-1){1'b0}}};
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return '0;
            default: return W'($urandom);
        endcase
    endfunction

    // Scoreboard and protocol monitor, sampling mid-cycle.
    always @(negedge clk) begin
        logic [PW-1:0] tot;
        exp_t          e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            check("in_ready", in_ready, (q.size() < LAT) || out_ready);
            if (stall_prev) begin
                check("stall_sum", sum, sv_s);
                check("stall_carry", carry, sv_c);
                check("stall_out_tc", out_tc, sv_t);
`ifdef MULT_CS_CPA_EN
                check("stall_product", product, sv_p);
`endif
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_delivery", out_valid, 1'b0);
                end else begin
                    e   = q.pop_front();
                    tot = sum + carry;
                    check("result", tot, e.p);
                    check("out_tc", out_tc, e.t);
`ifdef MULT_CS_CPA_EN
                    check("product", product, e.p);
`endif
                end
            end
            if (in_valid && in_ready) q.push_back('{cur_exp, tc});
            stall_prev = out_valid && !out_ready;
            sv_s = sum;
            sv_c = carry;
            sv_t = out_tc;
`ifdef MULT_CS_CPA_EN
            sv_p = product;
`endif
        end
    end

    // Single transaction into an empty pipe; checks accept-to-out_valid latency.
    task automatic send_one(input vec_t v);
        int lat;
        out_ready = 1'b1;
        a = v.a; b = v.b; tc = v.t; cur_exp = v.p;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, LAT);
        @(posedge clk); #1;
    endtask

    task automatic stream(input int n, input int rdy_pct, input int gap_pct);
        int   sent  = 0;
        int   guard = 0;
        logic hold  = 1'b0;
        while (sent < n && guard < 20000) begin
            out_ready = ($urandom_range(99) < rdy_pct);
            if (!hold) begin
                if ($urandom_range(99) < gap_pct) begin
                    in_valid = 1'b0;
                end else begin
                    in_valid = 1'b1;
                    a  = rnd_op();
                    b  = rnd_op();
                    tc = 1'($urandom_range(1));
                    cur_exp = ref_mul(a, b, tc);
                end
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                sent++;
                hold = 1'b0;
            end else begin
                hold = in_valid;
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        check("stream_sent", sent, n);
    endtask

    task automatic drain();
        int g = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (q.size() != 0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_empty", q.size(), 0);
        check("drain_out_valid", out_valid, 1'b0);
    endtask

    initial begin
        int acc;
        tbl[0] = '{16'hFFFF, 16'h0002, 1'b1, 32'hFFFF_FFFE};
        tbl[1] = '{16'hFFFF, 16'h0002, 1'b0, 32'h0001_FFFE};
        tbl[2] = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
        tbl[3] = '{16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 32'h4000_0000};
        tbl[7] = '{16'h1234, 16'h5678, 1'b0, 32'h0626_0060};
        tbl[8] = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF_0001};
        tbl[9] = '{16'h0000, 16'h1234, 1'b1, 32'h0000_0000};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; tc = 1'b0;
        out_ready = 1'b0; cur_exp = '0; stall_prev = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_sum", sum, 0);
        check("rst_carry", carry, 0);
        check("rst_out_tc", out_tc, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) send_one(tbl[i]);

        // Fill with the consumer stalled: exactly LAT pairs fit.
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        a = rnd_op(); b = rnd_op(); tc = 1'b1; cur_exp = ref_mul(a, b, tc);
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
            if (acc > 0) begin
                a = rnd_op(); b = rnd_op(); tc = ~tc; cur_exp = ref_mul(a, b, tc);
            end
        end
        check("capacity", acc, LAT);
        check("full_in_ready", in_ready, 1'b0);
        drain();

        stream(10, 50, 0);
        drain();

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a = rnd_op(); b = rnd_op(); tc = 1'($urandom_range(1)); cur_exp = ref_mul(a, b, tc);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("inflight_before_reset", q.size(), 2);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_sum", sum, 0);
        check("midrst_carry", carry, 0);
        check("midrst_in_ready", in_ready, 1'b1);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send_one(tbl[3]);
        send_one(tbl[0]);

        stream(400, 70, 30);
        drain();
        stream(200, 30, 10);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
